// File: rtl/calc_seq_if.sv
// Bundle of the keypad-token, converter and evaluator signals around calc_seq.
// The slave modport is the sequencer's view; master is the surrounding datapath.
interface calc_seq_if;
  logic        tok_valid;
  logic [32:0] tok_data;
  logic        tok_ready;
  logic        cv_clr;
  logic        cv_buf_not_empty;
  logic [32:0] cv_in;
  logic        cv_rd;
  logic        cv_wr;
  logic [32:0] cv_out;
  logic        cv_done;
  logic        ev_valid;
  logic [32:0] ev_data;
  logic        ev_done;
  logic [31:0] ev_result;
  logic        ev_err;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        err;
  logic [2:0]  err_code;

  modport slave (
    input  tok_valid, tok_data, cv_rd, cv_wr, cv_out, cv_done,
           ev_done, ev_result, ev_err,
    output tok_ready, cv_clr, cv_buf_not_empty, cv_in, ev_valid, ev_data,
           busy, result, result_valid, err, err_code
  );

  modport master (
    output tok_valid, tok_data, cv_rd, cv_wr, cv_out, cv_done,
           ev_done, ev_result, ev_err,
    input  tok_ready, cv_clr, cv_buf_not_empty, cv_in, ev_valid, ev_data,
           busy, result, result_valid, err, err_code
  );
endinterface

// File: rtl/calc_seq.sv
// Calculator sequencer: buffers one expression, checks parens, feeds the
// infix-to-postfix converter, syntax-checks its output and latches the result.
module calc_seq #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input logic       clk,
  input logic       rst,
  calc_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 2;
  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_LPAR  = 4'd5;
  localparam logic [3:0] OP_RPAR  = 4'd6;
  localparam logic [3:0] OP_STOP  = 4'd7;
  localparam logic [3:0] OP_CLEAR = 4'd8;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_PAREN   = 3'd1;
  localparam logic [2:0] ERR_OVF     = 3'd2;
  localparam logic [2:0] ERR_SYNTAX  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_ARITH   = 3'd5;

  localparam logic [32:0] STOP_TOKEN = {1'b1, 28'd0, OP_STOP};

  typedef enum logic [2:0] {
    IDLE, COLLECT, CONVERT, FLUSH, EVAL_WAIT, DONE, ERROR
  } state_t;

  state_t             state_reg, state_next;
  logic [32:0]        mem [DEPTH];
  logic [AW:0]        wr_ptr_reg, wr_ptr_next;
  logic [AW:0]        rd_ptr_reg, rd_ptr_next;
  logic signed [5:0]  paren_reg, paren_next;
  logic [DW-1:0]      depth_reg, depth_next;
  logic [IW-1:0]      idle_reg, idle_next;
  logic               cv_clr_reg, cv_clr_next;
  logic               ev_valid_reg, ev_valid_next;
  logic [32:0]        ev_data_reg, ev_data_next;
  logic [31:0]        result_reg, result_next;
  logic               result_valid_reg, result_valid_next;
  logic               err_reg, err_next;
  logic [2:0]         err_code_reg, err_code_next;
  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic               err_hit;
  logic [2:0]         err_hit_code;

  logic               tok_is_op, is_clear, restart, fifo_empty, base_full;
  logic [3:0]         tok_code;
  logic [AW:0]        base_wr, base_rd;
  logic signed [5:0]  base_paren, paren_inc, paren_dec;
  logic               cv_is_binary;

  assign tok_is_op  = bus.tok_data[32];
  assign tok_code   = bus.tok_data[3:0];
  assign is_clear   = bus.tok_valid && tok_is_op && (tok_code == OP_CLEAR);
  // A token arriving in IDLE/DONE/ERROR starts a fresh expression, so it is
  // evaluated against an empty FIFO and a zeroed paren counter.
  assign restart    = state_reg inside {IDLE, DONE, ERROR};
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign base_wr    = restart ? '0 : wr_ptr_reg;
  assign base_rd    = restart ? '0 : rd_ptr_reg;
  assign base_paren = restart ? 6'sd0 : paren_reg;
  assign paren_inc  = base_paren + 6'sd1;
  assign paren_dec  = base_paren - 6'sd1;
  assign base_full  = (base_wr[AW] != base_rd[AW]) &&
                      (base_wr[AW-1:0] == base_rd[AW-1:0]);
  assign cv_is_binary = bus.cv_out[32] && (bus.cv_out[3:0] >= OP_ADD) &&
                        (bus.cv_out[3:0] <= OP_DIV);

  always_comb begin
    state_next        = state_reg;
    wr_ptr_next       = wr_ptr_reg;
    rd_ptr_next       = rd_ptr_reg;
    paren_next        = paren_reg;
    depth_next        = depth_reg;
    idle_next         = '0;
    cv_clr_next       = 1'b0;
    ev_valid_next     = 1'b0;
    ev_data_next      = '0;
    result_next       = result_reg;
    result_valid_next = result_valid_reg;
    err_next          = err_reg;
    err_code_next     = err_code_reg;
    mem_we            = 1'b0;
    mem_waddr         = base_wr[AW-1:0];
    err_hit           = 1'b0;
    err_hit_code      = ERR_NONE;

    if (is_clear) begin
      state_next        = IDLE;
      wr_ptr_next       = '0;
      rd_ptr_next       = '0;
      paren_next        = 6'sd0;
      depth_next        = '0;
      cv_clr_next       = 1'b1;
      result_valid_next = 1'b0;
      err_next          = 1'b0;
      err_code_next     = ERR_NONE;
    end else begin
      case (state_reg)
        IDLE, COLLECT, DONE, ERROR: begin
          if (bus.tok_valid) begin
            if (restart) begin
              state_next        = COLLECT;
              wr_ptr_next       = '0;
              rd_ptr_next       = '0;
              paren_next        = 6'sd0;
              cv_clr_next       = 1'b1;
              result_valid_next = 1'b0;
              err_next          = 1'b0;
              err_code_next     = ERR_NONE;
            end
            if (base_full) begin
              err_hit      = 1'b1;
              err_hit_code = ERR_OVF;
            end else if (tok_is_op && tok_code == OP_RPAR && paren_dec < 6'sd0) begin
              err_hit      = 1'b1;
              err_hit_code = ERR_PAREN;
            end else begin
              mem_we      = 1'b1;
              wr_ptr_next = base_wr + (AW+1)'(1);
              if (tok_is_op && tok_code == OP_LPAR) paren_next = paren_inc;
              if (tok_is_op && tok_code == OP_RPAR) paren_next = paren_dec;
              if (tok_is_op && tok_code == OP_STOP) begin
                if (base_paren != 6'sd0) begin
                  err_hit      = 1'b1;
                  err_hit_code = ERR_PAREN;
                end else begin
                  state_next = CONVERT;
                  depth_next = '0;
                end
              end
            end
          end
        end
        CONVERT: begin
          if (bus.cv_rd && !fifo_empty) rd_ptr_next = rd_ptr_reg + (AW+1)'(1);
          // cv_done is only honoured on a cycle without cv_wr so the last
          // postfix token drains before FLUSH drives STOP.
          if (bus.cv_wr) begin
            if (cv_is_binary) begin
              if (depth_reg < DW'(2)) begin
                err_hit      = 1'b1;
                err_hit_code = ERR_SYNTAX;
              end else begin
                depth_next = depth_reg - DW'(1);
              end
            end else if (!bus.cv_out[32]) begin
              depth_next = depth_reg + DW'(1);
            end
          end else if (bus.cv_done) begin
            if (depth_reg == DW'(1)) begin
              state_next = FLUSH;
            end else begin
              err_hit      = 1'b1;
              err_hit_code = ERR_SYNTAX;
            end
          end else if (!bus.cv_rd) begin
            if (idle_reg == IW'(TIMEOUT - 1)) begin
              err_hit      = 1'b1;
              err_hit_code = ERR_TIMEOUT;
            end else begin
              idle_next = idle_reg + IW'(1);
            end
          end
        end
        FLUSH: state_next = EVAL_WAIT;
        EVAL_WAIT: begin
          if (bus.ev_done) begin
            if (bus.ev_err) begin
              err_hit      = 1'b1;
              err_hit_code = ERR_ARITH;
            end else begin
              result_next       = bus.ev_result;
              result_valid_next = 1'b1;
              state_next        = DONE;
            end
          end
        end
        default: state_next = IDLE;
      endcase

      if (err_hit) begin
        state_next        = ERROR;
        err_next          = 1'b1;
        err_code_next     = err_hit_code;
        result_valid_next = 1'b0;
      end
    end

    ev_valid_next = (state_reg == CONVERT) && bus.cv_wr && (state_next == CONVERT);
    ev_data_next  = ev_valid_next ? bus.cv_out : '0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= bus.tok_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      paren_reg        <= 6'sd0;
      depth_reg        <= '0;
      idle_reg         <= '0;
      cv_clr_reg       <= 1'b0;
      ev_valid_reg     <= 1'b0;
      ev_data_reg      <= '0;
      result_reg       <= '0;
      result_valid_reg <= 1'b0;
      err_reg          <= 1'b0;
      err_code_reg     <= ERR_NONE;
    end else begin
      state_reg        <= state_next;
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      paren_reg        <= paren_next;
      depth_reg        <= depth_next;
      idle_reg         <= idle_next;
      cv_clr_reg       <= cv_clr_next;
      ev_valid_reg     <= ev_valid_next;
      ev_data_reg      <= ev_data_next;
      result_reg       <= result_next;
      result_valid_reg <= result_valid_next;
      err_reg          <= err_next;
      err_code_reg     <= err_code_next;
    end
  end

  assign bus.tok_ready        = !rst && (state_reg inside {IDLE, COLLECT, DONE, ERROR});
  assign bus.cv_clr           = cv_clr_reg;
  assign bus.cv_buf_not_empty = (state_reg == CONVERT) && !fifo_empty;
  assign bus.cv_in            = fifo_empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign bus.ev_valid         = ev_valid_reg || (state_reg == FLUSH);
  assign bus.ev_data          = (state_reg == FLUSH) ? STOP_TOKEN : ev_data_reg;
  assign bus.busy             = state_reg inside {COLLECT, CONVERT, EVAL_WAIT};
  assign bus.result           = result_reg;
  assign bus.result_valid     = result_valid_reg;
  assign bus.err              = err_reg;
  assign bus.err_code         = err_code_reg;
endmodule
